// File: rtl/lut_const_prog.sv
// Writable operand-constant table for the decode stage.
// A pointer with its MSB set reads a table constant (const_flag = 1).
// A pointer with its MSB clear is a register pointer, passed through
// zero-extended or truncated (const_flag = 0).
// The table loads its default constants after reset or restore,
// then answers lookups with one cycle of registered latency.
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   ready               high only while the table is usable (RUN)
//   req_valid, ptr      lookup request and operand pointer
//   resp_valid          registered response strobe
//   constant            registered lookup result
//   const_flag          registered: 1 = table constant, 0 = register
//   wr_en, wr_addr,     run-time table write
//   wr_data
//   restore             reload all default constants
module lut_const_prog #(
    parameter int PTR_W  = 5,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              ready,
    input  logic              req_valid,
    input  logic [PTR_W-1:0]  ptr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] constant,
    output logic              const_flag,
    input  logic              wr_en,
    input  logic [PTR_W-2:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              restore
);

    localparam int AW    = PTR_W - 1;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              resp_q;
    logic [DATA_W-1:0] const_q, const_d;
    logic              flag_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              accept;
    logic              bypass;
    logic [AW-1:0]     rd_idx;

    // Default constant set; entries past the first 16 hold their own index.
    function automatic logic [DATA_W-1:0] dflt(input logic [AW-1:0] idx);
        logic [31:0] v;
        case (32'(idx))
            0:       v = 32'd127;
            1:       v = 32'd1;
            2:       v = 32'd2;
            3:       v = 32'd128;
            4:       v = 32'd8;
            5:       v = 32'd3;
            6:       v = 32'd4;
            7:       v = 32'd5;
            8:       v = 32'd32;
            9:       v = 32'd6;
            10:      v = 32'd15;
            11:      v = 32'd64;
            12:      v = 32'd7;
            13:      v = 32'd255;
            14:      v = 32'd19;
            15:      v = 32'd20;
            default: v = 32'(idx);
        endcase
        return DATA_W'(v);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_wa  = wr_addr;
        mem_wd  = wr_data;
        accept  = 1'b0;
        case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = dflt(cnt_q);
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                accept = req_valid;
                if (restore) begin
                    // Lookup still served; the concurrent write is dropped.
                    state_d = S_INIT;
                    cnt_d   = '0;
                end else begin
                    mem_we = wr_en;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Write-first: a same-index write in this cycle wins over the old entry.
    assign rd_idx = ptr[AW-1:0];
    assign bypass = (state_q == S_RUN) && wr_en && (wr_addr == rd_idx);

    always_comb begin
        const_d = DATA_W'(ptr);
        if (ptr[PTR_W-1]) begin
            const_d = bypass ? wr_data : mem_q[rd_idx];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            const_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= accept;
            if (accept) begin
                const_q <= const_d;
                flag_q  <= ptr[PTR_W-1];
            end
        end
    end

    // Table has no reset; INIT defines its contents.
    always_ff @(posedge Clk) begin
        if (!Reset && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign ready      = (state_q == S_RUN);
    assign resp_valid = resp_q;
    assign constant   = const_q;
    assign const_flag = flag_q;

endmodule

// File: tb/tb_lut_const_prog.sv
// Testbench for lut_const_prog: default and 6/16 parameterisations,
// scoreboard of expected responses checked by per-instance monitors.
module tb_lut_const_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] val;
        logic        flag;
    } exp_t;

    exp_t q5[$];
    exp_t q6[$];
    exp_t e5, e6;

    int DFLT[16] = '{127, 1, 2, 128, 8, 3, 4, 5, 32, 6, 15, 64, 7, 255, 19, 20};
    int m5[16];
    bit run5 = 1'b0;
    bit run6 = 1'b0;

    // ---------------- instance 5/8 ----------------
    logic       rst5 = 1'b1, rdy5, rv5 = 1'b0, vo5, f5, we5 = 1'b0, rs5 = 1'b0;
    logic [4:0] p5 = '0;
    logic [7:0] c5, wd5 = '0;
    logic [3:0] wa5 = '0;

    lut_const_prog #(.PTR_W(5), .DATA_W(8)) dut5 (
        .Clk(clk), .Reset(rst5), .ready(rdy5), .req_valid(rv5), .ptr(p5),
        .resp_valid(vo5), .constant(c5), .const_flag(f5), .wr_en(we5),
        .wr_addr(wa5), .wr_data(wd5), .restore(rs5)
    );

    // ---------------- instance 6/16 ----------------
    logic        rst6 = 1'b1, rdy6, rv6 = 1'b0, vo6, f6;
    logic [5:0]  p6 = '0;
    logic [15:0] c6;
    logic        we6 = 1'b0, rs6 = 1'b0;
    logic [4:0]  wa6 = '0;
    logic [15:0] wd6 = '0;

    lut_const_prog #(.PTR_W(6), .DATA_W(16)) dut6 (
        .Clk(clk), .Reset(rst6), .ready(rdy6), .req_valid(rv6), .ptr(p6),
        .resp_valid(vo6), .constant(c6), .const_flag(f6), .wr_en(we6),
        .wr_addr(wa6), .wr_data(wd6), .restore(rs6)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitors: pop one expectation per presented response.
    always @(negedge clk) begin
        if (vo5 !== 1'b0) begin
            if (q5.size() == 0) fail_now("resp5_unexpected");
            else begin
                e5 = q5.pop_front();
                chk("resp5_cycle", 32'(cyc), 32'(e5.due));
                chk("resp5_const", 32'(c5), 32'(e5.val));
                chk("resp5_flag", 32'(f5), 32'(e5.flag));
            end
        end else if (q5.size() > 0 && q5[0].due <= cyc) begin
            e5 = q5.pop_front();
            fail_now("resp5_missing");
        end
    end

    always @(negedge clk) begin
        if (vo6 !== 1'b0) begin
            if (q6.size() == 0) fail_now("resp6_unexpected");
            else begin
                e6 = q6.pop_front();
                chk("resp6_cycle", 32'(cyc), 32'(e6.due));
                chk("resp6_const", 32'(c6), 32'(e6.val));
                chk("resp6_flag", 32'(f6), 32'(e6.flag));
            end
        end else if (q6.size() > 0 && q6[0].due <= cyc) begin
            e6 = q6.pop_front();
            fail_now("resp6_missing");
        end
    end

    task automatic load_defaults5();
        for (int i = 0; i < 16; i++) m5[i] = DFLT[i];
    endtask

    // One cycle of stimulus on instance 5; called just after a rising edge.
    task automatic cyc5(input bit rv, input logic [4:0] p, input bit we,
                        input logic [3:0] wa, input logic [7:0] wd,
                        input bit rs);
        exp_t e;
        rv5 = rv; p5 = p; we5 = we; wa5 = wa; wd5 = wd; rs5 = rs;
        if (run5 && rv) begin
            e.due = cyc + 1;
            e.flag = p[4];
            if (!p[4]) e.val = 16'(p);
            else if (we && wa == p[3:0]) e.val = 16'(wd);
            else e.val = 16'(m5[p[3:0]] & 'hFF);
            q5.push_back(e);
        end
        if (run5 && we && !rs) m5[wa] = int'(wd);
        @(posedge clk);
        #1;
        rv5 = 1'b0; we5 = 1'b0; rs5 = 1'b0;
        if (run5 && rs) begin
            run5 = 1'b0;
            load_defaults5();
        end
    endtask

    // Counts rising edges until ready; optional requests while waiting.
    task automatic wait_rdy5(input string name, input int exp_n, input bit poke);
        int n = 0;
        while (rdy5 !== 1'b1 && n < 200) begin
            rv5 = poke;
            p5 = 5'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        rv5 = 1'b0;
        chk(name, 32'(n), 32'(exp_n));
        run5 = 1'b1;
    endtask

    task automatic look6(input logic [5:0] p);
        exp_t e;
        rv6 = 1'b1; p6 = p;
        if (run6) begin
            e.due = cyc + 1;
            e.flag = p[5];
            if (!p[5]) e.val = 16'(p);
            else if (p[4:0] < 16) e.val = 16'(DFLT[p[4:0]]);
            else e.val = 16'(p[4:0]);
            q6.push_back(e);
        end
        @(posedge clk);
        #1;
        rv6 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        @(posedge clk);
        #1;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_ready", 32'(rdy5), 32'd0);
        chk("rst_resp_valid", 32'(vo5), 32'd0);
        chk("rst_constant", 32'(c5), 32'd0);
        chk("rst_const_flag", 32'(f5), 32'd0);

        rst5 = 1'b0;
        wait_rdy5("ready_after_reset", 16, 1'b0);
        load_defaults5();

        cyc5(1, 5'b10000, 0, 0, 0, 0);
        cyc5(1, 5'b10011, 0, 0, 0, 0);
        cyc5(1, 5'b11101, 0, 0, 0, 0);
        cyc5(1, 5'b11111, 0, 0, 0, 0);
        cyc5(0, 0, 0, 0, 0, 0);

        cyc5(1, 5'b00111, 0, 0, 0, 0);
        cyc5(1, 5'b01111, 0, 0, 0, 0);
        cyc5(1, 5'b00000, 0, 0, 0, 0);
        cyc5(1, 5'b11000, 0, 0, 0, 0);
        cyc5(0, 0, 0, 0, 0, 0);

        cyc5(1, 5'b10011, 1, 4'd3, 8'hA5, 0);
        cyc5(0, 0, 0, 0, 0, 0);
        cyc5(1, 5'b10011, 0, 0, 0, 0);
        cyc5(1, 5'b10001, 1, 4'd3, 8'hA5, 0);
        cyc5(0, 0, 0, 0, 0, 0);

        cyc5(0, 0, 1, 4'd4, 8'h55, 1);
        wait_rdy5("ready_after_restore", 16, 1'b1);
        cyc5(1, 5'b10011, 0, 0, 0, 0);
        cyc5(1, 5'b10100, 0, 0, 0, 0);
        cyc5(0, 0, 0, 0, 0, 0);

        // Reset pulse, then a second one on INIT cycle 7.
        rst5 = 1'b1;
        run5 = 1'b0;
        @(posedge clk); #1;
        rst5 = 1'b0;
        repeat (7) begin
            rv5 = 1'b1; p5 = 5'($urandom);
            @(posedge clk); #1;
        end
        rv5 = 1'b0;
        chk("ready_low_mid_init", 32'(rdy5), 32'd0);
        rst5 = 1'b1;
        @(posedge clk); #1;
        rst5 = 1'b0;
        load_defaults5();
        wait_rdy5("ready_after_mid_init_reset", 16, 1'b1);

        repeat (300) begin
            cyc5(1'($urandom), 5'($urandom), ($urandom % 4) == 0,
                 4'($urandom), 8'($urandom), 0);
        end
        repeat (3) cyc5(0, 0, 0, 0, 0, 0);
        chk("q5_drained", 32'(q5.size()), 32'd0);

        // Wider instance.
        repeat (2) begin @(posedge clk); #1; end
        rst6 = 1'b0;
        n = 0;
        while (rdy6 !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready6_after_reset", 32'(n), 32'd32);
        run6 = 1'b1;
        look6(6'b110100);
        look6(6'b100000);
        look6(6'b011111);
        look6(6'b101101);
        look6(6'b111111);
        repeat (3) begin @(posedge clk); #1; end
        chk("q6_drained", 32'(q6.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
